gpio_in_debounce: RTL and testbench

//  Memory-mapped input port feeding memory_control's read path (mem1 read side).

---
 rtl/gpio_in_debounce.sv | 100 ++++++++++
 tb/tb_gpio_in_debounce.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Memory-mapped GPIO input port: 2-FF sync, per-bit debounce,
// sticky rising-edge flags with mask and level IRQ.
module gpio_in_debounce #(
  parameter int N_IN            = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [N_IN-1:0] pin_in,
  input  logic [1:0]      sel,
  input  logic            rd_ena,
  input  logic            wr_ena,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync_q;
  logic [N_IN-1:0] level_q;
  logic [N_IN-1:0] level_d;
  logic [N_IN-1:0] edge_q;
  logic [N_IN-1:0] mask_q;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] clr;
  logic [CW-1:0]   cnt_q [N_IN];
  logic [CW-1:0]   cnt_d [N_IN];
  logic            ev_sel;

  // Count saturates at CMAX; the level commits instead of wrapping.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync_q[i] != level_q[i]) begin
        if (cnt_q[i] == CMAX) begin
          level_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise   = level_d & ~level_q;
  assign ev_sel = (sel == 2'd1);

  always_comb begin
    clr = '0;
    if (rd_ena && ev_sel) begin
      clr = '1;
    end
    if (wr_ena && ev_sel) begin
      clr = clr | wdata[N_IN-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync1   <= '0;
      sync_q  <= '0;
      level_q <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1   <= pin_in;
      sync_q  <= sync1;
      level_q <= level_d;
      // A new rising edge outranks a clear on the same bit.
      edge_q  <= (edge_q & ~clr) | rise;
      if (wr_ena && sel == 2'd2) begin
        mask_q <= wdata[N_IN-1:0];
      end
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (RESET_N) begin
      unique case (1'b1)
        sel == 2'd0: rdata[N_IN-1:0] = level_q;
        sel == 2'd1: rdata[N_IN-1:0] = edge_q;
        sel == 2'd2: rdata[N_IN-1:0] = mask_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign irq = RESET_N & (|(edge_q & mask_q));

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce (N_IN=10, DEBOUNCE_CYCLES=4).
// Edge 0 is the last edge before a pin change becomes visible.
module tb_gpio_in_debounce;

  logic        CLK;
  logic        RESET_N;
  logic [9:0]  pin_in;
  logic [1:0]  sel;
  logic        rd_ena;
  logic        wr_ena;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp;
  int n_bad;

  gpio_in_debounce #(
    .N_IN(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .pin_in (pin_in),
    .sel    (sel),
    .rd_ena (rd_ena),
    .wr_ena (wr_ena),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] v);
    sel = s;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    sel    = s;
    wdata  = d;
    wr_ena = 1'b1;
    tick(1);
    wr_ena = 1'b0;
    wdata  = '0;
  endtask

  task automatic rclr();
    sel    = 2'd1;
    rd_ena = 1'b1;
    tick(1);
    rd_ena = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    RESET_N = 1'b0;
    pin_in  = 10'h3FF;
    sel     = 2'd0;
    rd_ena  = 1'b0;
    wr_ena  = 1'b0;
    wdata   = '0;

    // Reset with all pins high
    tick(3);
    rd(2'd0, v); chk("rst_level", v, 32'h0);
    rd(2'd1, v); chk("rst_edge", v, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    RESET_N = 1'b1;
    tick(5);
    rd(2'd0, v); chk("rel_level_e5", v, 32'h0);
    tick(1);
    rd(2'd0, v); chk("rel_level_e6", v, 32'h3FF);
    rd(2'd1, v); chk("rel_edge_e6", v, 32'h3FF);
    chk("rel_irq_mask0", {31'b0, irq}, 32'h0);

    // Read-to-clear, then falling edges set nothing
    rclr();
    rd(2'd1, v); chk("rclr_edge", v, 32'h0);
    pin_in = 10'h000;
    tick(8);
    rd(2'd0, v); chk("fall_level", v, 32'h0);
    rd(2'd1, v); chk("fall_edge", v, 32'h0);

    // Clean press on bit 3
    pin_in = 10'h008;
    tick(5);
    rd(2'd0, v); chk("press3_e5", v, 32'h0);
    tick(1);
    rd(2'd0, v); chk("press3_e6", v, 32'h008);
    rd(2'd1, v); chk("press3_edge", v, 32'h008);
    chk("press3_irq", {31'b0, irq}, 32'h0);

    // Glitch on bit 0 lasting 3 cycles
    pin_in = 10'h009;
    tick(3);
    pin_in = 10'h008;
    tick(12);
    rd(2'd0, v); chk("glitch_level", v, 32'h008);
    rd(2'd1, v); chk("glitch_edge", v, 32'h008);

    // W1C bit 3, release bit 3, then masked press
    wr(2'd1, 32'h008);
    rd(2'd1, v); chk("w1c3_edge", v, 32'h0);
    pin_in = 10'h000;
    tick(8);
    wr(2'd2, 32'h008);
    rd(2'd2, v); chk("mask_rd", v, 32'h008);
    chk("mask_irq0", {31'b0, irq}, 32'h0);
    pin_in = 10'h008;
    tick(6);
    chk("mask_irq1", {31'b0, irq}, 32'h1);
    sel    = 2'd1;
    rd_ena = 1'b1;
    #1;
    chk("irq_rd_pre", rdata, 32'h008);
    tick(1);
    rd_ena = 1'b0;
    rd(2'd1, v); chk("irq_rd_post", v, 32'h0);
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    // Collision: bit5 rises on the read-clear edge
    pin_in = 10'h00A;
    tick(6);
    rd(2'd1, v); chk("coll_pre_b1", v, 32'h002);
    pin_in = 10'h02A;
    tick(5);
    sel    = 2'd1;
    rd_ena = 1'b1;
    #1;
    chk("coll_rd", rdata, 32'h002);
    tick(1);
    rd_ena = 1'b0;
    rd(2'd1, v); chk("coll_edge", v, 32'h020);
    rd(2'd0, v); chk("coll_level", v, 32'h02A);

    // Writes to sel 0/3 are ignored
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd2, v); chk("ign_mask", v, 32'h008);
    rd(2'd1, v); chk("ign_edge", v, 32'h020);
    rd(2'd3, v); chk("sel3_zero", v, 32'h0);

    // W1C with EDGE=0x00C
    pin_in = 10'h022;
    tick(6);
    rclr();
    pin_in = 10'h02E;
    tick(6);
    rd(2'd1, v); chk("w1c_pre", v, 32'h00C);
    chk("w1c_irq_pre", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h004);
    rd(2'd1, v); chk("w1c_post", v, 32'h008);

    // Reset mid-debounce on bit 7
    pin_in = 10'h0AE;
    tick(3);
    pin_in  = 10'h000;
    RESET_N = 1'b0;
    tick(1);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    RESET_N = 1'b1;
    #1;
    rd(2'd0, v); chk("mid_rst_level", v, 32'h0);
    rd(2'd1, v); chk("mid_rst_edge", v, 32'h0);
    rd(2'd2, v); chk("mid_rst_mask", v, 32'h0);
    tick(10);
    rd(2'd0, v); chk("mid_rst_later", v, 32'h0);
    rd(2'd1, v); chk("mid_rst_edge_l", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
